// File: rtl/mem_hex_dumper.sv
// mem_hex_dumper: walks a memory address range and streams each word as an upper-case ASCII
// hex line (memh.txt format). Define MEM_DUMP_ADDR_EN to prefix the dump with an "@addr" line.
module mem_hex_dumper #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);
    localparam int NIB = DATA_W / 4;
`ifdef MEM_DUMP_ADDR_EN
    localparam int ANIB  = (ADDR_W + 3) / 4;
    localparam int AW4   = ANIB * 4;
    localparam int CNT_W = $clog2(((NIB > ANIB) ? NIB : ANIB) + 2);
`else
    localparam int CNT_W = $clog2(NIB + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef MEM_DUMP_ADDR_EN
        S_ADDR,
        S_ADDR_NL,
`endif
        S_READ,
        S_WAIT,
        S_EMIT,
        S_NL,
        S_FIN
    } state_t;

`ifdef MEM_DUMP_ADDR_EN
    localparam state_t S_FIRST = S_ADDR;
`else
    localparam state_t S_FIRST = S_READ;
`endif

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   end_reg;
    logic                desc_reg;
    logic [DATA_W-1:0]   word_reg;
    logic [CNT_W-1:0]    cnt_reg;
`ifdef MEM_DUMP_ADDR_EN
    logic [AW4-1:0]      aword_reg;
`endif
    logic                start_ok;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // A start is honoured whenever busy is low, which includes the FIN cycle.
    assign start_ok = start && (state_reg == S_IDLE || state_reg == S_FIN);
    assign mem_addr = addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state_reg)
            S_IDLE: begin
                if (start_ok) state_next = S_FIRST;
            end
`ifdef MEM_DUMP_ADDR_EN
            S_ADDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = (cnt_reg == '0) ? 8'h40 : hex_char(aword_reg[AW4-1 -: 4]);
                if (tx_ready && cnt_reg == CNT_W'(ANIB)) state_next = S_ADDR_NL;
            end
            S_ADDR_NL: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready) state_next = S_READ;
            end
`endif
            S_READ: begin
                busy       = 1'b1;
                mem_rd_en  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy       = 1'b1;
                state_next = S_EMIT;
            end
            S_EMIT: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = hex_char(word_reg[DATA_W-1 -: 4]);
                if (tx_ready && cnt_reg == CNT_W'(NIB - 1)) state_next = S_NL;
            end
            S_NL: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready) state_next = (addr_reg == end_reg) ? S_FIN : S_READ;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = start_ok ? S_FIRST : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: the word buffer shifts left one nibble per transferred digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            end_reg   <= '0;
            desc_reg  <= 1'b0;
            word_reg  <= '0;
            cnt_reg   <= '0;
`ifdef MEM_DUMP_ADDR_EN
            aword_reg <= '0;
`endif
        end else begin
            if (start_ok) begin
                addr_reg  <= start_addr;
                end_reg   <= end_addr;
                desc_reg  <= (start_addr > end_addr);
                cnt_reg   <= '0;
`ifdef MEM_DUMP_ADDR_EN
                aword_reg <= AW4'(start_addr);
`endif
            end
            case (state_reg)
`ifdef MEM_DUMP_ADDR_EN
                S_ADDR: begin
                    if (tx_ready) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg != '0) aword_reg <= aword_reg << 4;
                    end
                end
`endif
                S_WAIT: begin
                    word_reg <= mem_rd_data;
                    cnt_reg  <= '0;
                end
                S_EMIT: begin
                    if (tx_ready) begin
                        word_reg <= word_reg << 4;
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                    end
                end
                S_NL: begin
                    if (tx_ready && addr_reg != end_reg) begin
                        addr_reg <= desc_reg ? (addr_reg - ADDR_W'(1)) : (addr_reg + ADDR_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
